osd_blend: RTL and testbench
============================

# osd_blend

Parametrised on-screen-display mixer for the pixel-clock video path. It sits between the video source (RGB, syncs, blank) and vga2dvid. The block:
- counts active pixels and lines;
- exposes window-relative coordinates to an external glyph or colour source such as hex_decoder;
- overlays the returned colour inside a runtime-programmable rectangle, using one of three mix modes.

Window, enable and mode are shadowed at vsync, so the overlay never tears mid-frame.

## Interface
- C_depth, 8, bits per colour channel (video and OSD).
- C_x_bits, 11, width of x counter and window X registers.
- C_y_bits, 11, width of y counter and window Y registers.
- clk_pixel  in  1  pixel clock; all logic on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- i_r, i_g, i_b  in  C_depth each  input video.
- i_hsync, i_vsync, i_blank  in  1 each  input syncs and blank; vsync is active-high.
- i_osd_en  in  1  overlay enable (shadowed).
- i_mode  in  2  mix mode: 0 replace, 1 50 % blend, 2 colour-key, 3 replace (shadowed).
- i_x_start, i_x_stop  in  C_x_bits  window X bounds, half-open (shadowed).
- i_y_start, i_y_stop  in  C_y_bits  window Y bounds, half-open (shadowed).
- i_key  in  3*C_depth  key colour {r,g,b} for mode 2.
- o_osd_x  out  C_x_bits  window-relative x; 0 outside the window.
- o_osd_y  out  C_y_bits  window-relative y; 0 outside the window.
- i_osd_r, i_osd_g, i_osd_b  in  C_depth each  OSD colour; sampled exactly 1 clock after the matching o_osd_x/y.
- o_r, o_g, o_b  out  C_depth each  mixed video.
- o_hsync, o_vsync, o_blank  out  1 each  input syncs delayed to match the video.

## Operation
- **Counters (stage 0):**
  - x increments on every cycle with i_blank=0 and is cleared to 0 on every cycle with i_blank=1.
  - y increments on the i_blank 0→1 edge (end of an active line) and is cleared to 0 while i_vsync=1.
  - Both counters saturate at all-ones and do not wrap.
- **Shadowing:**
  - On an i_vsync 0→1 edge, latch i_osd_en, i_mode and the four bounds into shadow registers.
  - All mixing uses only the shadow values.
  - i_key is used live (it is not shadowed).
- **Window test:** in_win = sh_en & !blank & (x ≥ xs) & (x < xe) & (y ≥ ys) & (y < ye).
  - xe ≤ xs or ye ≤ ys gives an empty window (never in_win).
- **Coordinates:** o_osd_x = x − xs and o_osd_y = y − ys when in_win; otherwise 0. Both are registered at stage 0.
- **Mix (stage 1),** per channel, using the in_win flag delayed by 1 clock:
  - Not in window: output = delayed video.
  - Mode 0 or 3: output = osd.
  - Mode 1: output = (video + osd) >> 1, computed at C_depth+1 bits and truncated; no rounding.
  - Mode 2: output = video if {osd_r,osd_g,osd_b} == i_key, otherwise osd.
- **Blank override:** o_blank=1 forces o_r/o_g/o_b to 0, regardless of mode.

## Timing
- Video and sync latency is a fixed 2 clocks from i_* to o_*, in all modes and with the overlay disabled.
- o_osd_x/y are valid 1 clock after the corresponding input pixel.
- i_osd_* must be valid on the next clock; this matches a 1-cycle-latency font ROM.
- Reset values:
  - all outputs 0;
  - counters 0;
  - shadow enable 0, so the overlay is off until the first vsync edge after reset;
  - shadow bounds 0;
  - the sync edge detectors' "previous" regs 0.
- A vsync 0→1 edge and a bound change in the same cycle: the new bound values are latched.
- Reset asserted mid-frame: outputs go to 0 immediately (asynchronous). After release, the overlay stays off until the next vsync edge.

## Configuration
- OSD_BLEND_ALPHA_EN:
  - Defined: mode 1 performs the 50 % blend, with a C_depth+1 adder per channel.
  - Undefined: the adders are not synthesised and mode 1 behaves exactly as mode 0 (replace).
- Latency is identical in both builds.

## Test plan
- **Reset:** hold resetn=0 with video running → all outputs 0. Release → the output equals the input delayed 2 clocks, with no overlay before the first vsync edge.
- **Window placement:**
  - Setup: 1024×768 timing, window x 96..120, y 96..100, mode 0, OSD source returns 0xFF/0x00/0x00 (red).
  - Check line 96, x 96..119: red output with o_osd_x = 0..23.
  - Check x=95 and x=120: video passes through with o_osd_x = 0.
- **Blend:** video 0x80, osd 0xFF, mode 1 → 0xBF with OSD_BLEND_ALPHA_EN defined; 0xFF without it.
- **Colour key:** mode 2, key 0x000000, osd 0x000000 → video passes. Osd 0x010000 → 0x010000.
- **Shadowing:** change x_start from 96 to 200 mid-frame → the current frame still starts at 96. The next frame starts at 200 after the vsync edge.
- **Boundaries:**
  - x_stop = x_start → no overlay.
  - Blank asserted inside the window → o_r/g/b = 0.
  - A line of 4096 active pixels with C_x_bits=11 → x saturates at 2047 and does not wrap.

Source files
------------

// File: rtl/osd_blend.sv
// -----------------------------------------------------------------------------
// osd_blend -- on-screen-display mixer for the pixel-clock video path.
//
// Sits between the video source and the DVI encoder. It counts active pixels
// and lines, hands window-relative coordinates to an external glyph/colour
// source, and mixes the returned colour into the video inside a rectangle.
// Window bounds, enable and mix mode are captured on the rising edge of vsync
// so a frame is always drawn with one consistent configuration.
//
// Pipeline (video and syncs are delayed by exactly 2 clocks in every mode):
//   stage 0 : pixel/line counters, window test, coordinate output register
//   stage 1 : mix with the OSD colour returned one clock after the coordinates
//
// Build option:
//   OSD_BLEND_ALPHA_EN  defined   -> mode 1 is a 50 % blend (video+osd)>>1
//                       undefined -> mode 1 behaves as replace (mode 0)
//
// Ports:
//   clk_pixel                pixel clock, all logic on the rising edge
//   resetn                   asynchronous active-low reset
//   i_r/i_g/i_b              input video, C_depth bits per channel
//   i_hsync/i_vsync/i_blank  input syncs and blank (vsync active-high)
//   i_osd_en, i_mode         overlay enable and mix mode (shadowed at vsync)
//   i_x_start/i_x_stop       window X bounds, half-open (shadowed at vsync)
//   i_y_start/i_y_stop       window Y bounds, half-open (shadowed at vsync)
//   i_key                    colour key {r,g,b} for mode 2, used live
//   o_osd_x/o_osd_y          window-relative coordinates, 0 outside window
//   i_osd_r/i_osd_g/i_osd_b  OSD colour, valid 1 clock after o_osd_x/y
//   o_r/o_g/o_b              mixed video, forced to 0 while o_blank=1
//   o_hsync/o_vsync/o_blank  syncs delayed to line up with o_r/o_g/o_b
// -----------------------------------------------------------------------------
module osd_blend #(
    parameter int C_depth  = 8,
    parameter int C_x_bits = 11,
    parameter int C_y_bits = 11
) (
    input  logic                   clk_pixel,
    input  logic                   resetn,
    input  logic [C_depth-1:0]     i_r,
    input  logic [C_depth-1:0]     i_g,
    input  logic [C_depth-1:0]     i_b,
    input  logic                   i_hsync,
    input  logic                   i_vsync,
    input  logic                   i_blank,
    input  logic                   i_osd_en,
    input  logic [1:0]             i_mode,
    input  logic [C_x_bits-1:0]    i_x_start,
    input  logic [C_x_bits-1:0]    i_x_stop,
    input  logic [C_y_bits-1:0]    i_y_start,
    input  logic [C_y_bits-1:0]    i_y_stop,
    input  logic [3*C_depth-1:0]   i_key,
    output logic [C_x_bits-1:0]    o_osd_x,
    output logic [C_y_bits-1:0]    o_osd_y,
    input  logic [C_depth-1:0]     i_osd_r,
    input  logic [C_depth-1:0]     i_osd_g,
    input  logic [C_depth-1:0]     i_osd_b,
    output logic [C_depth-1:0]     o_r,
    output logic [C_depth-1:0]     o_g,
    output logic [C_depth-1:0]     o_b,
    output logic                   o_hsync,
    output logic                   o_vsync,
    output logic                   o_blank
);

    localparam logic [C_x_bits-1:0] X_MAX = {C_x_bits{1'b1}};
    localparam logic [C_y_bits-1:0] Y_MAX = {C_y_bits{1'b1}};

    // -------------------------------------------------------------------------
    // Per-channel mix. Only called for pixels inside the window.
    // Mode 1 without the alpha build falls through to plain replace so the
    // per-channel adders disappear from the netlist entirely.
    // -------------------------------------------------------------------------
    function automatic logic [C_depth-1:0] mix_ch(
        input logic [C_depth-1:0] vid,
        input logic [C_depth-1:0] osd,
        input logic [1:0]         mode,
        input logic               key_hit
    );
        logic [C_depth-1:0] res;
        res = osd;
        case (mode)
            2'd1: begin
`ifdef OSD_BLEND_ALPHA_EN
                // One extra bit holds the carry; the shift drops the LSB
                // (truncation, no rounding).
                res = C_depth'(({1'b0, vid} + {1'b0, osd}) >> 1);
`else
                res = osd;
`endif
            end
            2'd2: begin
                if (key_hit) begin
                    res = vid;
                end else begin
                    res = osd;
                end
            end
            default: res = osd;
        endcase
        return res;
    endfunction

    // ---------------------------------------------------------------- state --
    logic [C_x_bits-1:0] x_q, x_d;
    logic [C_y_bits-1:0] y_q, y_d;
    logic                blank_prev_q;
    logic                vsync_prev_q;

    logic                sh_en_q;
    logic [1:0]          sh_mode_q;
    logic [C_x_bits-1:0] sh_xs_q;
    logic [C_x_bits-1:0] sh_xe_q;
    logic [C_y_bits-1:0] sh_ys_q;
    logic [C_y_bits-1:0] sh_ye_q;

    // stage 0 outputs
    logic [C_x_bits-1:0] osd_x_q, osd_x_d;
    logic [C_y_bits-1:0] osd_y_q, osd_y_d;
    logic                in_win_q;
    logic [1:0]          mode1_q;
    logic [C_depth-1:0]  r1_q, g1_q, b1_q;
    logic                hs1_q, vs1_q, bl1_q;

    // stage 1 outputs
    logic [C_depth-1:0]  r2_q, g2_q, b2_q;
    logic [C_depth-1:0]  r2_d, g2_d, b2_d;
    logic                hs2_q, vs2_q, bl2_q;

    // combinational helpers
    logic                vsync_rise_s;
    logic                line_end_s;
    logic                in_win_s;
    logic                key_hit_s;

    assign vsync_rise_s = i_vsync & ~vsync_prev_q;
    // Blank going high marks the end of an active line.
    assign line_end_s   = i_blank & ~blank_prev_q;

    // Next-state for the saturating pixel (x) and line (y) counters.
    always_comb begin
        x_d = x_q;
        y_d = y_q;

        if (i_blank) begin
            x_d = '0;
        end else if (x_q != X_MAX) begin
            x_d = x_q + 1'b1;
        end else begin
            x_d = x_q;
        end

        if (i_vsync) begin
            y_d = '0;
        end else if (line_end_s && (y_q != Y_MAX)) begin
            y_d = y_q + 1'b1;
        end else begin
            y_d = y_q;
        end
    end

    // Window test and window-relative coordinates for the current pixel.
    // x_q/y_q are the coordinates of the pixel presented on the inputs now.
    // An inverted or zero-size window can never satisfy both compares.
    always_comb begin
        in_win_s = 1'b0;
        osd_x_d  = '0;
        osd_y_d  = '0;
        if (sh_en_q && !i_blank &&
            (x_q >= sh_xs_q) && (x_q < sh_xe_q) &&
            (y_q >= sh_ys_q) && (y_q < sh_ye_q)) begin
            in_win_s = 1'b1;
            osd_x_d  = x_q - sh_xs_q;
            osd_y_d  = y_q - sh_ys_q;
        end else begin
            in_win_s = 1'b0;
            osd_x_d  = '0;
            osd_y_d  = '0;
        end
    end

    // Counters and the edge-detector history bits.
    always_ff @(posedge clk_pixel or negedge resetn) begin
        if (!resetn) begin
            x_q          <= '0;
            y_q          <= '0;
            blank_prev_q <= 1'b0;
            vsync_prev_q <= 1'b0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            blank_prev_q <= i_blank;
            vsync_prev_q <= i_vsync;
        end
    end

    // Shadow copy of the window configuration, captured on vsync rising edge.
    always_ff @(posedge clk_pixel or negedge resetn) begin
        if (!resetn) begin
            sh_en_q   <= 1'b0;
            sh_mode_q <= 2'd0;
            sh_xs_q   <= '0;
            sh_xe_q   <= '0;
            sh_ys_q   <= '0;
            sh_ye_q   <= '0;
        end else if (vsync_rise_s) begin
            sh_en_q   <= i_osd_en;
            sh_mode_q <= i_mode;
            sh_xs_q   <= i_x_start;
            sh_xe_q   <= i_x_stop;
            sh_ys_q   <= i_y_start;
            sh_ye_q   <= i_y_stop;
        end
    end

    // Stage 0 pipeline register: coordinates out, video/syncs and window flag
    // carried along so they meet the OSD colour arriving one clock later.
    // The mode travels with the pixel so a vsync capture cannot change the
    // mode of a pixel already in flight.
    always_ff @(posedge clk_pixel or negedge resetn) begin
        if (!resetn) begin
            osd_x_q  <= '0;
            osd_y_q  <= '0;
            in_win_q <= 1'b0;
            mode1_q  <= 2'd0;
            r1_q     <= '0;
            g1_q     <= '0;
            b1_q     <= '0;
            hs1_q    <= 1'b0;
            vs1_q    <= 1'b0;
            bl1_q    <= 1'b0;
        end else begin
            osd_x_q  <= osd_x_d;
            osd_y_q  <= osd_y_d;
            in_win_q <= in_win_s;
            mode1_q  <= sh_mode_q;
            r1_q     <= i_r;
            g1_q     <= i_g;
            b1_q     <= i_b;
            hs1_q    <= i_hsync;
            vs1_q    <= i_vsync;
            bl1_q    <= i_blank;
        end
    end

    // Stage 1 mix. The key compares against the live key register.
    always_comb begin
        key_hit_s = ({i_osd_r, i_osd_g, i_osd_b} == i_key);
        r2_d      = r1_q;
        g2_d      = g1_q;
        b2_d      = b1_q;
        if (bl1_q) begin
            // blank wins over every mode
            r2_d = '0;
            g2_d = '0;
            b2_d = '0;
        end else if (in_win_q) begin
            r2_d = mix_ch(r1_q, i_osd_r, mode1_q, key_hit_s);
            g2_d = mix_ch(g1_q, i_osd_g, mode1_q, key_hit_s);
            b2_d = mix_ch(b1_q, i_osd_b, mode1_q, key_hit_s);
        end else begin
            r2_d = r1_q;
            g2_d = g1_q;
            b2_d = b1_q;
        end
    end

    // Stage 1 output register.
    always_ff @(posedge clk_pixel or negedge resetn) begin
        if (!resetn) begin
            r2_q  <= '0;
            g2_q  <= '0;
            b2_q  <= '0;
            hs2_q <= 1'b0;
            vs2_q <= 1'b0;
            bl2_q <= 1'b0;
        end else begin
            r2_q  <= r2_d;
            g2_q  <= g2_d;
            b2_q  <= b2_d;
            hs2_q <= hs1_q;
            vs2_q <= vs1_q;
            bl2_q <= bl1_q;
        end
    end

    assign o_osd_x = osd_x_q;
    assign o_osd_y = osd_y_q;
    assign o_r     = r2_q;
    assign o_g     = g2_q;
    assign o_b     = b2_q;
    assign o_hsync = hs2_q;
    assign o_vsync = vs2_q;
    assign o_blank = bl2_q;

endmodule

// File: tb/tb_osd_blend.sv
// -----------------------------------------------------------------------------
// tb_osd_blend -- self-checking bench for osd_blend.
// A reference model tracks pixel/line position, the vsync-captured window and
// the expected mix result of every pixel; coordinates are compared 1 clock and
// video/syncs 2 clocks after the pixel is driven.
// -----------------------------------------------------------------------------
module tb_osd_blend;

    localparam int CD   = 8;
    localparam int CX   = 11;
    localparam int CY   = 11;
    localparam int KW   = 3 * CD;
    localparam int XMAX = (1 << CX) - 1;
    localparam int YMAX = (1 << CY) - 1;

    logic            clk_pixel = 1'b0;
    logic            resetn;
    logic [CD-1:0]   i_r, i_g, i_b;
    logic            i_hsync, i_vsync, i_blank;
    logic            i_osd_en;
    logic [1:0]      i_mode;
    logic [CX-1:0]   i_x_start, i_x_stop;
    logic [CY-1:0]   i_y_start, i_y_stop;
    logic [KW-1:0]   i_key;
    logic [CX-1:0]   o_osd_x;
    logic [CY-1:0]   o_osd_y;
    logic [CD-1:0]   i_osd_r, i_osd_g, i_osd_b;
    logic [CD-1:0]   o_r, o_g, o_b;
    logic            o_hsync, o_vsync, o_blank;

    osd_blend #(.C_depth(CD), .C_x_bits(CX), .C_y_bits(CY)) dut (
        .clk_pixel(clk_pixel), .resetn(resetn),
        .i_r(i_r), .i_g(i_g), .i_b(i_b),
        .i_hsync(i_hsync), .i_vsync(i_vsync), .i_blank(i_blank),
        .i_osd_en(i_osd_en), .i_mode(i_mode),
        .i_x_start(i_x_start), .i_x_stop(i_x_stop),
        .i_y_start(i_y_start), .i_y_stop(i_y_stop),
        .i_key(i_key),
        .o_osd_x(o_osd_x), .o_osd_y(o_osd_y),
        .i_osd_r(i_osd_r), .i_osd_g(i_osd_g), .i_osd_b(i_osd_b),
        .o_r(o_r), .o_g(o_g), .o_b(o_b),
        .o_hsync(o_hsync), .o_vsync(o_vsync), .o_blank(o_blank)
    );

    always #5 clk_pixel = ~clk_pixel;

    typedef struct {
        int r, g, b;
        bit hs, vs, bl;
        bit inwin;
        int ox, oy;
        int mode;
        int er, eg, eb;
    } pix_t;

    // reference model state
    int   mx, my;
    bit   pb, pv;
    bit   sh_en;
    int   sh_mode, sh_xs, sh_xe, sh_ys, sh_ye;
    pix_t p1, p2;
    pix_t zero_pix;
    bit   in_reset;
    int   osd_sel;   // 0 red, 1 alternate 0x000000/0x010000, 2 white, 3 random/key
    int   vid_sel;   // 0 random, 1 constant 0x80 grey
    bit   alt_tog;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int mix(input int v, input int o, input int mode, input bit km);
        case (mode)
`ifdef OSD_BLEND_ALPHA_EN
            1:       return (v + o) / 2;
`else
            1:       return o;
`endif
            2:       return km ? v : o;
            default: return o;
        endcase
    endfunction

    function automatic logic [63:0] all_out();
        return 64'({o_osd_x, o_osd_y, o_r, o_g, o_b, o_hsync, o_vsync, o_blank});
    endfunction

    function automatic logic [63:0] exp_vid(input pix_t p);
        logic [CD-1:0] r, g, b;
        r = CD'(p.er);
        g = CD'(p.eg);
        b = CD'(p.eb);
        return 64'({r, g, b, p.hs, p.vs, p.bl});
    endfunction

    // Model one pixel from the values currently driven onto the inputs.
    task automatic model_pixel(output pix_t p);
        p       = zero_pix;
        p.r     = int'(i_r);
        p.g     = int'(i_g);
        p.b     = int'(i_b);
        p.hs    = i_hsync;
        p.vs    = i_vsync;
        p.bl    = i_blank;
        p.inwin = sh_en && !i_blank && mx >= sh_xs && mx < sh_xe && my >= sh_ys && my < sh_ye;
        p.ox    = p.inwin ? mx - sh_xs : 0;
        p.oy    = p.inwin ? my - sh_ys : 0;
        p.mode  = sh_mode;
        if (i_vsync && !pv) begin
            sh_en   = i_osd_en;
            sh_mode = int'(i_mode);
            sh_xs   = int'(i_x_start);
            sh_xe   = int'(i_x_stop);
            sh_ys   = int'(i_y_start);
            sh_ye   = int'(i_y_stop);
        end
        if (i_blank)      mx = 0;
        else if (mx < XMAX) mx = mx + 1;
        if (i_vsync)      my = 0;
        else if (i_blank && !pb && my < YMAX) my = my + 1;
        pb = i_blank;
        pv = i_vsync;
    endtask

    task automatic pick_osd(output logic [KW-1:0] oc);
        case (osd_sel)
            0: oc = KW'(24'hFF0000);
            1: begin
                alt_tog = ~alt_tog;
                oc = alt_tog ? KW'(24'h010000) : KW'(24'h000000);
            end
            2: oc = KW'(24'hFFFFFF);
            default: oc = ($urandom_range(1) == 1) ? i_key : KW'($urandom);
        endcase
    endtask

    // One pixel clock: check outputs, return the OSD colour for the previous
    // pixel, then drive the next pixel.
    task automatic step(input bit bl, input bit vs, input bit hs);
        logic [KW-1:0] oc;
        bit km;
        @(posedge clk_pixel);
        #1;
        if (in_reset) begin
            chk("reset_outputs", all_out(), 64'd0);
        end else begin
            chk("osd_xy", 64'({o_osd_x, o_osd_y}), 64'({CX'(p1.ox), CY'(p1.oy)}));
            chk("video", 64'({o_r, o_g, o_b, o_hsync, o_vsync, o_blank}), exp_vid(p2));
        end
        pick_osd(oc);
        {i_osd_r, i_osd_g, i_osd_b} = oc;
        if (!in_reset) begin
            if (p1.bl) begin
                p1.er = 0; p1.eg = 0; p1.eb = 0;
            end else if (!p1.inwin) begin
                p1.er = p1.r; p1.eg = p1.g; p1.eb = p1.b;
            end else begin
                km    = (oc == i_key);
                p1.er = mix(p1.r, int'(oc[3*CD-1 -: CD]), p1.mode, km);
                p1.eg = mix(p1.g, int'(oc[2*CD-1 -: CD]), p1.mode, km);
                p1.eb = mix(p1.b, int'(oc[CD-1 -: CD]),   p1.mode, km);
            end
            p2 = p1;
        end
        if (vid_sel == 1) begin
            i_r = CD'(8'h80); i_g = CD'(8'h80); i_b = CD'(8'h80);
        end else begin
            i_r = CD'($urandom); i_g = CD'($urandom); i_b = CD'($urandom);
        end
        i_blank = bl;
        i_vsync = vs;
        i_hsync = hs;
        if (!in_reset) model_pixel(p1);
    endtask

    task automatic release_reset();
        resetn   = 1'b1;
        in_reset = 1'b0;
        mx = 0; my = 0; pb = 1'b0; pv = 1'b0;
        sh_en = 1'b0; sh_mode = 0; sh_xs = 0; sh_xe = 0; sh_ys = 0; sh_ye = 0;
        p2 = zero_pix;
        model_pixel(p1);
    endtask

    task automatic set_regs(input bit en, input int mode, input int xs, input int xe,
                            input int ys, input int ye);
        i_osd_en  = en;
        i_mode    = 2'(mode);
        i_x_start = CX'(xs);
        i_x_stop  = CX'(xe);
        i_y_start = CY'(ys);
        i_y_stop  = CY'(ye);
    endtask

    task automatic run_lines(input int w, input int n, input bit glitch);
        for (int l = 0; l < n; l++) begin
            for (int i = 0; i < w; i++) step(glitch && ($urandom_range(15) == 0), 1'b0, 1'b0);
            for (int i = 0; i < 4; i++) step(1'b1, 1'b0, (i == 1 || i == 2));
        end
    endtask

    task automatic run_vblank(input int w);
        for (int l = 0; l < 3; l++)
            for (int i = 0; i < w + 4; i++) step(1'b1, (l == 1), 1'b0);
    endtask

    initial begin
        zero_pix = '{default: 0};
        p1 = zero_pix;
        p2 = zero_pix;
        resetn = 1'b0;
        in_reset = 1'b1;
        i_r = '0; i_g = '0; i_b = '0;
        i_hsync = 1'b0; i_vsync = 1'b0; i_blank = 1'b1;
        i_osd_r = '0; i_osd_g = '0; i_osd_b = '0;
        i_key = '0;
        osd_sel = 0; vid_sel = 0; alt_tog = 1'b0;
        set_regs(1'b1, 0, 0, 100, 0, 100);

        // reset with video running
        #1;
        chk("reset_async_t0", all_out(), 64'd0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0);
        release_reset();

        // overlay must stay off before the first vsync edge
        run_lines(16, 3, 1'b0);

        // window placement, red OSD, mode 0
        set_regs(1'b1, 0, 96, 120, 96, 100);
        run_vblank(128);
        run_lines(128, 50, 1'b0);
        // mid-frame change: current frame keeps 96, next frame uses 200
        i_x_start = CX'(200); i_x_stop = CX'(220);
        i_y_start = CY'(1);   i_y_stop = CY'(3);
        run_lines(128, 52, 1'b0);
        run_vblank(224);
        run_lines(224, 4, 1'b0);

        // 50 % blend: grey 0x80 with white OSD
        set_regs(1'b1, 1, 0, 8, 0, 2);
        osd_sel = 2; vid_sel = 1;
        run_vblank(12);
        run_lines(12, 3, 1'b0);

        // colour key: key 0, OSD alternates 0x000000 / 0x010000
        set_regs(1'b1, 2, 0, 8, 0, 2);
        i_key = '0; osd_sel = 1; vid_sel = 0;
        run_vblank(12);
        run_lines(12, 3, 1'b0);

        // empty windows: x_stop == x_start, then y_stop < y_start
        set_regs(1'b1, 0, 4, 4, 0, 2);
        osd_sel = 0;
        run_vblank(12);
        run_lines(12, 3, 1'b0);
        set_regs(1'b1, 3, 0, 8, 2, 1);
        run_vblank(12);
        run_lines(12, 3, 1'b0);

        // x saturation on a 4100-pixel line; a wrap would re-enter x 0..7
        set_regs(1'b1, 0, 0, 8, 0, 2);
        run_vblank(12);
        run_lines(4100, 1, 1'b0);

        // reset asserted mid-frame inside an active window
        set_regs(1'b1, 0, 0, 8, 0, 4);
        run_vblank(16);
        run_lines(16, 1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        #2;
        resetn = 1'b0;
        #1;
        chk("reset_async_mid", all_out(), 64'd0);
        in_reset = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
        release_reset();
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0);
        run_lines(16, 3, 1'b0);

        // randomized frames with blank glitches inside the active area
        osd_sel = 3;
        for (int f = 0; f < 8; f++) begin
            set_regs($urandom_range(7) != 0, int'($urandom_range(3)),
                     int'($urandom_range(40)), int'($urandom_range(48)),
                     int'($urandom_range(4)), int'($urandom_range(6)));
            i_key = ($urandom_range(1) == 1) ? KW'(0) : KW'($urandom);
            run_vblank(64);
            run_lines(64, 8, 1'b1);
        end
        run_vblank(16);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
